// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared FSM encodings and SDRAM command constants
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_ACT   = 4'b0011;
  localparam logic [3:0]  CMD_RD    = 4'b0101;
  localparam logic [3:0]  CMD_WR    = 4'b0100;
  localparam logic [3:0]  CMD_PRE   = 4'b0010;
  localparam logic [3:0]  CMD_AREF  = 4'b0001;

  localparam logic [1:0]  IDLE_BANK = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1fff;

endpackage

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - engine handshakes and SDRAM pin bundle for the arbiter
interface sdram_arbit_if #(
  parameter int CMD_W = 4,
  parameter int BA_W  = 2,
  parameter int A_W   = 13,
  parameter int DQ_W  = 16
);
  logic              init_end;
  logic [CMD_W-1:0]  init_cmd;
  logic [BA_W-1:0]   init_bank;
  logic [A_W-1:0]    init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [CMD_W-1:0]  aref_cmd;
  logic [BA_W-1:0]   aref_bank;
  logic [A_W-1:0]    aref_addr;
  logic              aref_en;

  logic              wr_req;
  logic              wr_end;
  logic [CMD_W-1:0]  wr_cmd;
  logic [BA_W-1:0]   wr_bank;
  logic [A_W-1:0]    wr_addr;
  logic [DQ_W-1:0]   wr_data;
  logic              wr_sdram_en;
  logic              wr_en;

  logic              rd_req;
  logic              rd_end;
  logic [CMD_W-1:0]  rd_cmd;
  logic [BA_W-1:0]   rd_bank;
  logic [A_W-1:0]    rd_addr;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [A_W-1:0]    sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_out;
  logic              sdram_dq_oe;

  // arbiter side
  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    output aref_en,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_data, wr_sdram_en,
    output wr_en,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  // engines and pin side
  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    input  aref_en,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_data, wr_sdram_en,
    input  wr_en,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );
endinterface

// File: rtl/sdram_cmd_mux.sv
// rtl/sdram_cmd_mux.sv - combinational cmd/bank/addr selector keyed on arbiter state
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int CMD_W = 4,
  parameter int BA_W  = 2,
  parameter int A_W   = 13
) (
  input  arb_state_t        i_state,
  input  logic [CMD_W-1:0]  i_init_cmd,
  input  logic [BA_W-1:0]   i_init_bank,
  input  logic [A_W-1:0]    i_init_addr,
  input  logic [CMD_W-1:0]  i_aref_cmd,
  input  logic [BA_W-1:0]   i_aref_bank,
  input  logic [A_W-1:0]    i_aref_addr,
  input  logic [CMD_W-1:0]  i_wr_cmd,
  input  logic [BA_W-1:0]   i_wr_bank,
  input  logic [A_W-1:0]    i_wr_addr,
  input  logic [CMD_W-1:0]  i_rd_cmd,
  input  logic [BA_W-1:0]   i_rd_bank,
  input  logic [A_W-1:0]    i_rd_addr,
  output logic [CMD_W-1:0]  o_cmd,
  output logic [BA_W-1:0]   o_bank,
  output logic [A_W-1:0]    o_addr
);

  always_comb begin
    o_cmd  = CMD_W'(CMD_NOP);
    o_bank = BA_W'(IDLE_BANK);
    o_addr = A_W'(IDLE_ADDR);
    case (i_state)
      ST_INIT: begin
        o_cmd  = i_init_cmd;
        o_bank = i_init_bank;
        o_addr = i_init_addr;
      end
      ST_AREF: begin
        o_cmd  = i_aref_cmd;
        o_bank = i_aref_bank;
        o_addr = i_aref_addr;
      end
      ST_WRITE: begin
        o_cmd  = i_wr_cmd;
        o_bank = i_wr_bank;
        o_addr = i_wr_addr;
      end
      ST_READ: begin
        o_cmd  = i_rd_cmd;
        o_bank = i_rd_bank;
        o_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter; SDRAM_ARB_RR_EN enables write/read round-robin
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int CMD_W = 4,
  parameter int BA_W  = 2,
  parameter int A_W   = 13,
  parameter int DQ_W  = 16
) (
  input  logic          arb_clk,
  input  logic          arb_rst_n,
  sdram_arbit_if.slave  bus
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              w_rd_turn;
  logic [CMD_W-1:0]  w_cmd;
  logic [BA_W-1:0]   w_bank;
  logic [A_W-1:0]    w_addr;

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) r_state <= ST_INIT;
    else            r_state <= w_next_state;
  end

  // Requests are only looked at in ARBIT; ends only from the granted engine.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:  if (bus.init_end) w_next_state = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.aref_req)                                 w_next_state = ST_AREF;
        else if (bus.wr_req && !(bus.rd_req && w_rd_turn)) w_next_state = ST_WRITE;
        else if (bus.rd_req)                              w_next_state = ST_READ;
      end
      ST_AREF:  if (bus.aref_end) w_next_state = ST_ARBIT;
      ST_WRITE: if (bus.wr_end)   w_next_state = ST_ARBIT;
      ST_READ:  if (bus.rd_end)   w_next_state = ST_ARBIT;
      default:  w_next_state = ST_INIT;
    endcase
  end

`ifdef SDRAM_ARB_RR_EN
  logic r_last_rw;

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n)
      r_last_rw <= 1'b0;
    else if (r_state == ST_ARBIT && w_next_state == ST_WRITE)
      r_last_rw <= 1'b1;
    else if (r_state == ST_ARBIT && w_next_state == ST_READ)
      r_last_rw <= 1'b0;
  end

  assign w_rd_turn = r_last_rw;
`else
  assign w_rd_turn = 1'b0;
`endif

  sdram_cmd_mux #(
    .CMD_W (CMD_W),
    .BA_W  (BA_W),
    .A_W   (A_W)
  ) u_cmd_mux (
    .i_state     (r_state),
    .i_init_cmd  (bus.init_cmd),
    .i_init_bank (bus.init_bank),
    .i_init_addr (bus.init_addr),
    .i_aref_cmd  (bus.aref_cmd),
    .i_aref_bank (bus.aref_bank),
    .i_aref_addr (bus.aref_addr),
    .i_wr_cmd    (bus.wr_cmd),
    .i_wr_bank   (bus.wr_bank),
    .i_wr_addr   (bus.wr_addr),
    .i_rd_cmd    (bus.rd_cmd),
    .i_rd_bank   (bus.rd_bank),
    .i_rd_addr   (bus.rd_addr),
    .o_cmd       (w_cmd),
    .o_bank      (w_bank),
    .o_addr      (w_addr)
  );

  assign bus.aref_en      = (r_state == ST_AREF);
  assign bus.wr_en        = (r_state == ST_WRITE);
  assign bus.rd_en        = (r_state == ST_READ);

  assign bus.sdram_cke    = arb_rst_n;
  assign bus.sdram_cs_n   = w_cmd[CMD_W-1];
  assign bus.sdram_ras_n  = w_cmd[CMD_W-2];
  assign bus.sdram_cas_n  = w_cmd[CMD_W-3];
  assign bus.sdram_we_n   = w_cmd[CMD_W-4];
  assign bus.sdram_ba     = w_bank;
  assign bus.sdram_addr   = w_addr;
  assign bus.sdram_dq_out = bus.wr_data;
  assign bus.sdram_dq_oe  = (r_state == ST_WRITE) && bus.wr_sdram_en;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  sdram_arbit_if bus ();

  sdram_arbit dut (
    .arb_clk   (clk),
    .arb_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0]  INIT_CMD = 4'b0010, AREF_CMD = 4'b0001, WR_CMD = 4'b0100, RD_CMD = 4'b0101;
  localparam logic [1:0]  INIT_BA  = 2'b01,   AREF_BA  = 2'b00,   WR_BA  = 2'b10,   RD_BA  = 2'b01;
  localparam logic [12:0] INIT_A   = 13'h0400, AREF_A  = 13'h0000, WR_A  = 13'h0123, RD_A  = 13'h0456;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_pins(input string tag, input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] a);
    check({tag, "_cmd"}, {28'd0, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n}, {28'd0, cmd});
    check({tag, "_ba"}, {30'd0, bus.sdram_ba}, {30'd0, ba});
    check({tag, "_addr"}, {19'd0, bus.sdram_addr}, {19'd0, a});
  endtask

  // expected {aref_en, wr_en, rd_en}
  task automatic check_gnt(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.aref_en, bus.wr_en, bus.rd_en}, {29'd0, exp});
  endtask

  logic [2:0] exp_first;
  logic [2:0] exp_second;
  logic [4:0] oe_pat;

  initial begin
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b0;
    bus.init_end = 0; bus.init_cmd = INIT_CMD; bus.init_bank = INIT_BA; bus.init_addr = INIT_A;
    bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = AREF_CMD; bus.aref_bank = AREF_BA; bus.aref_addr = AREF_A;
    bus.wr_req = 0; bus.wr_end = 0; bus.wr_cmd = WR_CMD; bus.wr_bank = WR_BA; bus.wr_addr = WR_A;
    bus.wr_data = 16'hA5A5; bus.wr_sdram_en = 0;
    bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = RD_CMD; bus.rd_bank = RD_BA; bus.rd_addr = RD_A;

    tick;
    check_gnt("rst_gnt", 3'b000);
    check("rst_cke", {31'd0, bus.sdram_cke}, 32'd0);
    check("rst_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check_pins("rst_pins", INIT_CMD, INIT_BA, INIT_A);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick;
      check_pins("init_pins", INIT_CMD, INIT_BA, INIT_A);
      check_gnt("init_gnt", 3'b000);
    end
    bus.init_end = 1;
    check("cke_run", {31'd0, bus.sdram_cke}, 32'd1);
    tick;
    check_pins("arbit_pins", 4'b0111, 2'b11, 13'h1fff);
    tick;
    check_gnt("arbit_idle", 3'b000);

    // all three requests at once
    bus.aref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
    tick;
    check_gnt("prio_aref", 3'b100);
    check_pins("aref_pins", AREF_CMD, AREF_BA, AREF_A);
    bus.aref_req = 0; bus.aref_end = 1;
    tick;
    bus.aref_end = 0;
    check_gnt("gap1", 3'b000);
    check_pins("gap1_pins", 4'b0111, 2'b11, 13'h1fff);
    tick;
    check_gnt("prio_wr", 3'b010);
    check_pins("wr_pins", WR_CMD, WR_BA, WR_A);
    bus.wr_req = 0;
    tick;
    check_gnt("wr_hold", 3'b010);
    bus.wr_end = 1;
    tick;
    bus.wr_end = 0;
    check_gnt("gap2", 3'b000);
    tick;
    check_gnt("prio_rd", 3'b001);
    check_pins("rd_pins", RD_CMD, RD_BA, RD_A);
    bus.rd_req = 0; bus.rd_end = 1;
    tick;
    bus.rd_end = 0;
    check_gnt("gap3", 3'b000);

    // simultaneous write/read twice
`ifdef SDRAM_ARB_RR_EN
    exp_first = 3'b010; exp_second = 3'b001;
`else
    exp_first = 3'b010; exp_second = 3'b010;
`endif
    bus.wr_req = 1; bus.rd_req = 1;
    tick;
    check_gnt("rw_first", exp_first);
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_end = 1; bus.rd_end = 1;
    tick;
    bus.wr_end = 0; bus.rd_end = 0;
    check_gnt("rw_gap1", 3'b000);
    bus.wr_req = 1; bus.rd_req = 1;
    tick;
    check_gnt("rw_second", exp_second);
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_end = 1; bus.rd_end = 1;
    tick;
    bus.wr_end = 0; bus.rd_end = 0;
    check_gnt("rw_gap2", 3'b000);

    // refresh request arriving mid-read
    bus.rd_req = 1;
    tick;
    check_gnt("rd_start", 3'b001);
    bus.rd_req = 0; bus.aref_req = 1;
    tick;
    check_gnt("rd_no_preempt1", 3'b001);
    tick;
    check_gnt("rd_no_preempt2", 3'b001);
    bus.rd_end = 1;
    tick;
    bus.rd_end = 0;
    check_gnt("rd_end_gap", 3'b000);
    tick;
    check_gnt("aref_after_rd", 3'b100);
    bus.aref_req = 0; bus.aref_end = 1;
    tick;
    bus.aref_end = 0;
    check_gnt("aref_done", 3'b000);

    // DQ output enable during and outside WRITE
    bus.wr_sdram_en = 1;
    #1;
    check("oe_arbit", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("dq_out", {16'd0, bus.sdram_dq_out}, 32'h0000A5A5);
    bus.wr_req = 1;
    tick;
    bus.wr_req = 0;
    check_gnt("wr_dq_start", 3'b010);
    oe_pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      bus.wr_sdram_en = oe_pat[i];
      #1;
      check("oe_track", {31'd0, bus.sdram_dq_oe}, {31'd0, oe_pat[i]});
      tick;
    end
    bus.wr_sdram_en = 1;
    bus.wr_end = 1;
    tick;
    bus.wr_end = 0;
    check("oe_after_wr", {31'd0, bus.sdram_dq_oe}, 32'd0);

    // spurious ends during READ
    bus.rd_req = 1;
    tick;
    bus.rd_req = 0;
    check("oe_read", {31'd0, bus.sdram_dq_oe}, 32'd0);
    bus.wr_end = 1; bus.aref_end = 1;
    tick;
    bus.wr_end = 0; bus.aref_end = 0;
    check_gnt("spurious_end", 3'b001);
    check_pins("spurious_pins", RD_CMD, RD_BA, RD_A);
    bus.rd_end = 1;
    tick;
    bus.rd_end = 0;
    check_gnt("rd_done", 3'b000);

    // reset mid-write
    bus.wr_req = 1;
    tick;
    bus.wr_req = 0;
    check("oe_pre_rst", {31'd0, bus.sdram_dq_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_gnt("rst_mid_gnt", 3'b000);
    check("rst_mid_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("rst_mid_cke", {31'd0, bus.sdram_cke}, 32'd0);
    check_pins("rst_mid_pins", INIT_CMD, INIT_BA, INIT_A);
    tick;
    rst_n = 1'b1;
    #1;
    check_pins("post_rst_init", INIT_CMD, INIT_BA, INIT_A);
    tick;
    check_pins("post_rst_arbit", 4'b0111, 2'b11, 13'h1fff);
    check_gnt("post_rst_gnt", 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
